ifetch_stage: RTL and testbench
===============================

Name: ifetch_stage

Overview:
Instruction-fetch stage feeding the ID stage of the MIPS pipeline.
- Holds the PC, the instruction memory and the IF/ID pipeline register (IFID_IR, IFID_PCplus4, IFID_Valid).
- Supports stall, flush and branch redirect from downstream stages.
- Provides a memory load port so benches and the CPU top can load a program.

Parameters:
IMEM_WORDS, 1024, instruction memory depth in 32-bit words (power of two).
RESET_PC, 32'h00000000, PC value after reset.

Ports:
clock  input  1  pipeline clock; all state updates on negedge clock, matching the rest of the pipeline.
reset  input  1  asynchronous, active-high reset.
Stall  input  1  hold PC and IF/ID (load-use or structural hazard).
Flush  input  1  replace the IF/ID contents with a bubble.
PCSrc  input  1  redirect fetch to BranchTarget.
BranchTarget  input  32  redirect address.
IMemWE  input  1  instruction memory write enable.
IMemAddr  input  log2(IMEM_WORDS)  word address for load.
IMemData  input  32  word to load.
PC  output  32  current fetch address.
IFID_IR  output  32  fetched instruction to ID.
IFID_PCplus4  output  32  PC+4 of the instruction in IFID_IR.
IFID_Valid  output  1  IFID_IR is a real instruction, not a bubble.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - PC=RESET_PC
  - IFID_IR=32'h00000000 (nop)
  - IFID_PCplus4=0
  - IFID_Valid=0
  - Instruction memory is not cleared.
- Memory loading:
  - IMemWE is honoured on negedge clock even while reset is high.
- Fetch read:
  - Combinational, word = IMemory[PC[log2(IMEM_WORDS)+1:2]].
  - PC[1:0] are ignored.
  - If PC>>2 >= IMEM_WORDS, the fetched word is 0. Any upper PC bits set counts as out of range.
- Latency: the instruction at PC appears on IFID_IR one negedge after PC presents it.
- Update on each negedge clock, in priority order:
  1. PCSrc=1:
     - PC <= {BranchTarget[31:2],2'b00}.
     - IFID_IR <= 0, IFID_PCplus4 <= 0, IFID_Valid <= 0 (squash the wrong-path fetch).
     - Overrides Stall and Flush.
  2. Stall=1 and Flush=1: PC holds; IF/ID becomes a bubble (IR=0, PCplus4=0, Valid=0).
  3. Stall=1: PC, IFID_IR, IFID_PCplus4 and IFID_Valid all hold.
  4. Flush=1:
     - PC <= PC+4.
     - IF/ID becomes a bubble (IR=0, PCplus4=0, Valid=0).
  5. Otherwise:
     - PC <= PC+4.
     - IFID_IR <= fetched word, IFID_PCplus4 <= PC+4.
     - IFID_Valid <= 1 if in range, else 0.
- PC+4 is computed modulo 2^32: 32'hFFFFFFFC wraps to 0.
- Simultaneous IMemWE to the word being fetched: the fetch gets the old word (read-before-write); the new word is visible next cycle.
- Reset asserted mid-stall or mid-redirect: immediate return to reset values. No pending redirect survives.
- Outputs are registered; none depend combinationally on Stall, Flush or PCSrc.

Optional Feature:
Macro IFETCH_STATS_EN.
- Defined:
  - Adds outputs FetchCount[31:0] and BubbleCount[31:0], both reset to 0.
  - FetchCount increments on each negedge where IFID_Valid is loaded with 1.
  - BubbleCount increments on each negedge where IF/ID is loaded with a bubble. This covers PCSrc, Flush, Stall+Flush and out-of-range cases; a plain Stall does not count.
  - Both counters wrap at 2^32.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load words 0..3 = 2009000f, 200a0007, 012a5824, 012b5022 with reset high, then release reset.
  -> After negedges 1..4: IFID_IR = 2009000f, 200a0007, 012a5824, 012b5022; IFID_PCplus4 = 4, 8, 12, 16; PC = 16 after negedge 4; Valid=1.
- Same program, Stall=1 for 2 cycles after the first fetch.
  -> IFID_IR stays 2009000f and PC stays 4 for 2 cycles, then 200a0007 with PC=8.
- At PC=8, PCSrc=1 with BranchTarget=32'h00000002, Stall=1 on the same edge.
  -> PC=0, IFID_IR=0, Valid=0; the next edge gives IFID_IR=2009000f.
- Flush=1 at PC=4.
  -> IFID_IR=0, Valid=0, PC=8; the next edge gives IFID_IR=012a5824.
- With IMEM_WORDS=16, PC reaches 64.
  -> IFID_IR=0, Valid=0, PC=68. Force PC to FFFFFFFC via redirect; the next PC is 0.
- Assert reset asynchronously between edges during a stall.
  -> PC=RESET_PC and IFID_Valid=0 immediately. With IFETCH_STATS_EN, FetchCount and BubbleCount read 0.

Source files
------------

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: PC, instruction memory and the IF/ID register, updated on negedge clock.
// Optional fetch/bubble counters are enabled by defining IFETCH_STATS_EN.
module ifetch_stage #(
   parameter int unsigned IMEM_WORDS = 1024,
   parameter logic [31:0] RESET_PC   = 32'h00000000
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          Stall,
   input  logic                          Flush,
   input  logic                          PCSrc,
   input  logic [31:0]                   BranchTarget,
   input  logic                          IMemWE,
   input  logic [$clog2(IMEM_WORDS)-1:0] IMemAddr,
   input  logic [31:0]                   IMemData,
`ifdef IFETCH_STATS_EN
   output logic [31:0]                   FetchCount,
   output logic [31:0]                   BubbleCount,
`endif
   output logic [31:0]                   PC,
   output logic [31:0]                   IFID_IR,
   output logic [31:0]                   IFID_PCplus4,
   output logic                          IFID_Valid
);

   localparam int unsigned AW = $clog2(IMEM_WORDS);

   logic [31:0] imem [IMEM_WORDS];
   logic [31:0] pc_plus4;
   logic [31:0] fetch_word;
   logic        in_range;

   assign pc_plus4   = PC + 32'd4;
   // Any PC bit above the memory's word index means the fetch is off the end of memory.
   assign in_range   = (PC[31:AW+2] == '0);
   assign fetch_word = in_range ? imem[PC[AW+1:2]] : 32'h00000000;

   // Not reset, and written even during reset so a program can be loaded before release.
   always_ff @(negedge clock) begin
      if (IMemWE) begin
         imem[IMemAddr] <= IMemData;
      end
   end

   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         PC           <= RESET_PC;
         IFID_IR      <= 32'h00000000;
         IFID_PCplus4 <= 32'h00000000;
         IFID_Valid   <= 1'b0;
      end else if (PCSrc) begin
         PC           <= BranchTarget & 32'hFFFFFFFC;
         IFID_IR      <= 32'h00000000;
         IFID_PCplus4 <= 32'h00000000;
         IFID_Valid   <= 1'b0;
      end else if (Stall && Flush) begin
         IFID_IR      <= 32'h00000000;
         IFID_PCplus4 <= 32'h00000000;
         IFID_Valid   <= 1'b0;
      end else if (Stall) begin
         PC           <= PC;
      end else if (Flush) begin
         PC           <= pc_plus4;
         IFID_IR      <= 32'h00000000;
         IFID_PCplus4 <= 32'h00000000;
         IFID_Valid   <= 1'b0;
      end else begin
         PC           <= pc_plus4;
         IFID_IR      <= fetch_word;
         IFID_PCplus4 <= pc_plus4;
         IFID_Valid   <= in_range;
      end
   end

`ifdef IFETCH_STATS_EN
   logic load_fetch;
   logic load_bubble;

   assign load_fetch  = !PCSrc && !Stall && !Flush && in_range;
   assign load_bubble = PCSrc || Flush || (!Stall && !in_range);

   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         FetchCount  <= 32'h00000000;
         BubbleCount <= 32'h00000000;
      end else begin
         if (load_fetch) begin
            FetchCount <= FetchCount + 32'd1;
         end
         if (load_bubble) begin
            BubbleCount <= BubbleCount + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: directed program steps, then random stall/flush/redirect/load traffic
// compared against a fetch-rule model. Checks counters too when IFETCH_STATS_EN is defined.
module tb_ifetch_stage;

   localparam int unsigned WORDS = 16;

   logic        clock = 1'b1;
   logic        reset = 1'b1;
   logic        Stall = 1'b0, Flush = 1'b0, PCSrc = 1'b0, IMemWE = 1'b0;
   logic [31:0] BranchTarget = '0, IMemData = '0;
   logic [3:0]  IMemAddr = '0;
   logic [31:0] PC, IFID_IR, IFID_PCplus4;
   logic        IFID_Valid;
`ifdef IFETCH_STATS_EN
   logic [31:0] FetchCount, BubbleCount;
`endif

   int errors = 0;
   int checks = 0;

   // Reference state
   logic [31:0] mem [WORDS];
   logic [31:0] m_pc = '0, m_ir = '0, m_p4 = '0, m_fc = '0, m_bc = '0;
   logic        m_valid = 1'b0;

   ifetch_stage #(.IMEM_WORDS(WORDS), .RESET_PC(32'h00000000)) dut (
      .clock       (clock),
      .reset       (reset),
      .Stall       (Stall),
      .Flush       (Flush),
      .PCSrc       (PCSrc),
      .BranchTarget(BranchTarget),
      .IMemWE      (IMemWE),
      .IMemAddr    (IMemAddr),
      .IMemData    (IMemData),
`ifdef IFETCH_STATS_EN
      .FetchCount  (FetchCount),
      .BubbleCount (BubbleCount),
`endif
      .PC          (PC),
      .IFID_IR     (IFID_IR),
      .IFID_PCplus4(IFID_PCplus4),
      .IFID_Valid  (IFID_Valid)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_pc"}, PC, m_pc);
      chk({tag, "_ir"}, IFID_IR, m_ir);
      chk({tag, "_pcplus4"}, IFID_PCplus4, m_p4);
      chk({tag, "_valid"}, {31'd0, IFID_Valid}, {31'd0, m_valid});
`ifdef IFETCH_STATS_EN
      chk({tag, "_fetchcount"}, FetchCount, m_fc);
      chk({tag, "_bubblecount"}, BubbleCount, m_bc);
`endif
   endtask

   task automatic model_reset();
      m_pc = 32'h00000000; m_ir = '0; m_p4 = '0; m_valid = 1'b0; m_fc = '0; m_bc = '0;
   endtask

   task automatic bubble();
      m_ir = '0; m_p4 = '0; m_valid = 1'b0; m_bc = m_bc + 1;
   endtask

   // Advance the model by one negedge using the current inputs, then compare after the edge.
   task automatic step(input string tag);
      logic        inr;
      logic [31:0] word;
      inr  = (m_pc / 4) < WORDS;
      word = inr ? mem[m_pc / 4] : 32'h0;
      if (reset) begin
         model_reset();
      end else if (PCSrc) begin
         m_pc = (BranchTarget / 4) * 4;
         bubble();
      end else if (Stall && Flush) begin
         bubble();
      end else if (Stall) begin
         m_pc = m_pc;
      end else if (Flush) begin
         m_pc = m_pc + 4;
         bubble();
      end else begin
         m_ir = word; m_p4 = m_pc + 4; m_valid = inr; m_pc = m_pc + 4;
         if (inr) m_fc = m_fc + 1;
         else m_bc = m_bc + 1;
      end
      if (IMemWE) mem[IMemAddr] = IMemData;
      @(negedge clock);
      #1;
      check_all(tag);
   endtask

   task automatic async_reset_pulse(input string tag);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] prog [4];
      prog[0] = 32'h2009000f; prog[1] = 32'h200a0007;
      prog[2] = 32'h012a5824; prog[3] = 32'h012b5022;
      for (int i = 0; i < WORDS; i++) mem[i] = '0;

      // Load the program while reset is held.
      for (int i = 0; i < WORDS; i++) begin
         IMemWE = 1'b1; IMemAddr = 4'(i);
         IMemData = (i < 4) ? prog[i] : $urandom;
         step("load");
      end
      IMemWE = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step("run");
         chk("tp_ir", IFID_IR, prog[i]);
         chk("tp_pcplus4", IFID_PCplus4, 32'(4 * (i + 1)));
      end
      chk("tp_pc16", PC, 32'd16);

      // Stall holds the first fetch for two cycles.
      reset = 1'b1; step("rst2"); reset = 1'b0;
      step("fetch1");
      Stall = 1'b1; step("stall_a"); step("stall_b");
      chk("stall_ir", IFID_IR, 32'h2009000f);
      chk("stall_pc", PC, 32'd4);
      Stall = 1'b0; step("unstall");
      chk("unstall_ir", IFID_IR, 32'h200a0007);
      chk("unstall_pc", PC, 32'd8);

      // Redirect wins over a simultaneous stall; target low bits are dropped.
      PCSrc = 1'b1; BranchTarget = 32'h00000002; Stall = 1'b1; step("redirect");
      chk("redir_pc", PC, 32'd0);
      chk("redir_valid", {31'd0, IFID_Valid}, 32'd0);
      PCSrc = 1'b0; Stall = 1'b0; step("after_redir");
      chk("after_redir_ir", IFID_IR, 32'h2009000f);

      Flush = 1'b1; step("flush");
      chk("flush_pc", PC, 32'd8);
      chk("flush_ir", IFID_IR, 32'd0);
      Flush = 1'b0; step("after_flush");
      chk("after_flush_ir", IFID_IR, 32'h012a5824);

      // Run off the end of memory, then wrap PC through the top of the address space.
      for (int i = 0; i < 13; i++) step("walk");
      chk("walk_pc64", PC, 32'd64);
      step("oor");
      chk("oor_pc", PC, 32'd68);
      chk("oor_valid", {31'd0, IFID_Valid}, 32'd0);
      chk("oor_ir", IFID_IR, 32'd0);
      PCSrc = 1'b1; BranchTarget = 32'hFFFFFFFF; step("to_top");
      chk("top_pc", PC, 32'hFFFFFFFC);
      PCSrc = 1'b0; step("wrap");
      chk("wrap_pc", PC, 32'd0);
      chk("wrap_pcplus4", IFID_PCplus4, 32'd0);

      // Asynchronous reset in the middle of a stall.
      Stall = 1'b1; step("pre_async");
      async_reset_pulse("async_rst");
      Stall = 1'b0; step("post_async");

      // Same-word load during fetch: the fetch sees the old word.
      IMemWE = 1'b1; IMemAddr = 4'd1; IMemData = 32'hCAFEF00D; step("rbw");
      chk("rbw_ir", IFID_IR, 32'h200a0007);
      IMemWE = 1'b0;

      for (int n = 0; n < 400; n++) begin
         Stall  = ($urandom % 4) == 0;
         Flush  = ($urandom % 6) == 0;
         PCSrc  = ($urandom % 7) == 0;
         BranchTarget = (($urandom % 8) == 0) ? $urandom : $urandom_range(0, 80);
         IMemWE = ($urandom % 3) == 0;
         IMemAddr = 4'($urandom);
         IMemData = $urandom;
         step("rand");
         if (($urandom % 40) == 0) async_reset_pulse("rand_async");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
